// File: rtl/sound_pkg.sv
// Shared constants for the sound channel register front ends.
package sound_pkg;

  // Noise channel register addresses (NR41..NR44)
  localparam logic [15:0] ADDR_NR41 = 16'hFF20;
  localparam logic [15:0] ADDR_NR42 = 16'hFF21;
  localparam logic [15:0] ADDR_NR43 = 16'hFF22;
  localparam logic [15:0] ADDR_NR44 = 16'hFF23;

  // NR44 reads back only bit 6; every other bit reads as 1
  localparam logic [7:0] NR44_READ_MASK = 8'hBF;

  // 4.194304 MHz CPU clock / 512 Hz frame sequencer
  localparam int FS_DIV_DEFAULT = 8192;

  // Default width of the trigger pulse in clocks
  localparam int START_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sound_frame_seq.sv
// 512 Hz frame sequencer: prescaler, 3-bit step counter and registered
// length (256 Hz) and envelope (64 Hz) clock decodes.
module sound_frame_seq
  import sound_pkg::*;
#(
  parameter int FS_DIV = FS_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [2:0] step,
  output logic       clk_length_ctr,
  output logic       clk_vol_env
);

  localparam int PW = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(FS_DIV - 1);

  logic [PW-1:0] prescaler;

  // Prescaler wraps every FS_DIV clocks and advances step; held at 0 while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      step      <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      step      <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      step      <= step + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Clock decodes lag step by one clock so they are glitch-free registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_length_ctr <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else if (!enable) begin
      clk_length_ctr <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      clk_length_ctr <= ~step[0];
      clk_vol_env    <= (step == 3'd7);
    end
  end

endmodule

// File: rtl/sound_noise_ctrl.sv
// Noise channel register front end: NR41..NR44 decode, trigger pulse
// generation and the frame sequencer that clocks length and envelope.
module sound_noise_ctrl
  import sound_pkg::*;
#(
  parameter int FS_DIV       = FS_DIV_DEFAULT,
  parameter int START_CYCLES = START_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sound_enable,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [3:0]  shift_clock_freq,
  output logic        counter_width,
  output logic [2:0]  freq_dividing_ratio,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_vol_env
);

  localparam int SW = $clog2(START_CYCLES + 1);
  localparam logic [SW-1:0] START_LOAD = SW'(START_CYCLES);

  logic [5:0]    nr41_len;
  logic [7:0]    nr42;
  logic [7:0]    nr43;
  logic          nr44_single;
  logic [SW-1:0] start_cnt;
  logic          trigger;
  logic [2:0]    unused_fs_step;
  logic          unused_rd;

  // Reads are combinational, so the strobe carries no information here
  assign unused_rd = rd;

  assign trigger = wr && sound_enable && (addr == ADDR_NR44) && din[7];

  // Field registers: loaded on matching writes, forced to 0 while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nr41_len    <= '0;
      nr42        <= '0;
      nr43        <= '0;
      nr44_single <= 1'b0;
    end else if (!sound_enable) begin
      nr41_len    <= '0;
      nr42        <= '0;
      nr43        <= '0;
      nr44_single <= 1'b0;
    end else if (wr) begin
      case (addr)
        ADDR_NR41: nr41_len    <= din[5:0];
        ADDR_NR42: nr42        <= din;
        ADDR_NR43: nr43        <= din;
        ADDR_NR44: nr44_single <= din[6];
        default: ;
      endcase
    end
  end

  // Trigger counter: a trigger (re)loads it, otherwise it counts down to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt <= '0;
    end else if (!sound_enable) begin
      start_cnt <= '0;
    end else if (trigger) begin
      start_cnt <= START_LOAD;
    end else if (start_cnt != '0) begin
      start_cnt <= start_cnt - 1'b1;
    end
  end

  // Read mux: write-only and unmapped addresses return all ones
  always_comb begin
    dout = 8'hFF;
    case (addr)
      ADDR_NR42: dout = nr42;
      ADDR_NR43: dout = nr43;
      ADDR_NR44: dout = NR44_READ_MASK | {1'b0, nr44_single, 6'b0};
      default:   dout = 8'hFF;
    endcase
  end

  assign start               = (start_cnt != '0);
  assign length              = nr41_len;
  assign initial_volume      = nr42[7:4];
  assign envelope_increasing = nr42[3];
  assign num_envelope_sweeps = nr42[2:0];
  assign shift_clock_freq    = nr43[7:4];
  assign counter_width       = nr43[3];
  assign freq_dividing_ratio = nr43[2:0];
  assign single              = nr44_single;

  sound_frame_seq #(
    .FS_DIV(FS_DIV)
  ) u_frame_seq (
    .clk            (clk),
    .rst            (rst),
    .enable         (sound_enable),
    .step           (unused_fs_step),
    .clk_length_ctr (clk_length_ctr),
    .clk_vol_env    (clk_vol_env)
  );

endmodule

// File: tb/tb_sound_noise_ctrl.sv
// Bench for sound_noise_ctrl: directed scenarios followed by random bus
// traffic, every cycle compared against a cycle-count based reference model.
module tb_sound_noise_ctrl;

  localparam int FS_DIV       = 4;
  localparam int START_CYCLES = 4;

  logic        clk;
  logic        rst;
  logic        sound_enable;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr;
  logic        rd;
  logic [7:0]  dout;
  logic [5:0]  length;
  logic [3:0]  initial_volume;
  logic        envelope_increasing;
  logic [2:0]  num_envelope_sweeps;
  logic [3:0]  shift_clock_freq;
  logic        counter_width;
  logic [2:0]  freq_dividing_ratio;
  logic        single;
  logic        start;
  logic        clk_length_ctr;
  logic        clk_vol_env;

  sound_noise_ctrl #(
    .FS_DIV       (FS_DIV),
    .START_CYCLES (START_CYCLES)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sound_enable        (sound_enable),
    .addr                (addr),
    .din                 (din),
    .wr                  (wr),
    .rd                  (rd),
    .dout                (dout),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .shift_clock_freq    (shift_clock_freq),
    .counter_width       (counter_width),
    .freq_dividing_ratio (freq_dividing_ratio),
    .single              (single),
    .start               (start),
    .clk_length_ctr      (clk_length_ctr),
    .clk_vol_env         (clk_vol_env)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  // Registers hold the raw bytes the CPU wrote; the frame clocks are derived
  // from the number of enabled clock edges since reset/enable.
  logic [5:0] m_len;
  logic [7:0] m_nr42;
  logic [7:0] m_nr43;
  logic       m_single;
  int         m_start_end;   // last sampled cycle at which start is high
  int         m_ticks;       // enabled edges seen since reset / re-enable
  logic       m_lc;
  logic       m_ve;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_len       = '0;
    m_nr42      = '0;
    m_nr43      = '0;
    m_single    = 1'b0;
    m_start_end = -1;
    m_ticks     = 0;
    m_lc        = 1'b0;
    m_ve        = 1'b0;
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    case (a)
      16'hFF21: exp_read = m_nr42;
      16'hFF22: exp_read = m_nr43;
      16'hFF23: exp_read = m_single ? 8'hFF : 8'hBF;
      default:  exp_read = 8'hFF;
    endcase
  endfunction

  task automatic compare_all();
    check("dout",      {8'h0, dout},                {8'h0, exp_read(addr)});
    check("length",    {10'h0, length},             {10'h0, m_len});
    check("init_vol",  {12'h0, initial_volume},     {12'h0, m_nr42[7:4]});
    check("env_inc",   {15'h0, envelope_increasing},{15'h0, m_nr42[3]});
    check("env_sweep", {13'h0, num_envelope_sweeps},{13'h0, m_nr42[2:0]});
    check("shift_clk", {12'h0, shift_clock_freq},   {12'h0, m_nr43[7:4]});
    check("cnt_width", {15'h0, counter_width},      {15'h0, m_nr43[3]});
    check("div_ratio", {13'h0, freq_dividing_ratio},{13'h0, m_nr43[2:0]});
    check("single",    {15'h0, single},             {15'h0, m_single});
    check("start",     {15'h0, start},              {15'h0, (cyc <= m_start_end)});
    check("clk_len",   {15'h0, clk_length_ctr},     {15'h0, m_lc});
    check("clk_env",   {15'h0, clk_vol_env},        {15'h0, m_ve});
  endtask

  // One clock: apply the model to the inputs present at the edge, then compare
  task automatic tick();
    logic        e;
    logic        w;
    logic        r;
    logic [15:0] a;
    logic [7:0]  d;
    int          s;
    e = sound_enable; w = wr; a = addr; d = din; r = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      model_reset();
    end else if (!e) begin
      model_reset();
    end else begin
      s = (m_ticks / FS_DIV) % 8;
      m_lc = (s % 2) == 0;
      m_ve = (s == 7);
      m_ticks++;
      if (w) begin
        case (a)
          16'hFF20: m_len  = d[5:0];
          16'hFF21: m_nr42 = d;
          16'hFF22: m_nr43 = d;
          16'hFF23: begin
            m_single = d[6];
            if (d[7]) m_start_end = cyc + START_CYCLES - 1;
          end
          default: ;
        endcase
      end
    end
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; din = d; wr = 1'b1; rd = 1'b0;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a);
    addr = a; wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- stimulus ----------------
  int first_ve;

  initial begin
    rst = 1'b1; sound_enable = 1'b1; addr = 16'h0000; din = 8'h00; wr = 1'b0; rd = 1'b0;
    model_reset();
    #1;
    check("reset_start", {15'h0, start}, 16'h0);
    apply_reset();

    // Frame sequencer from reset: envelope clock first rises at 7*FS_DIV+1
    first_ve = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clk_vol_env && first_ve < 0) first_ve = cyc;
    end
    check("first_ve", 16'(first_ve), 16'(7 * FS_DIV + 1));

    // Register round-trip
    bus_write(16'hFF21, 8'hA5);
    bus_read(16'hFF21);
    check("rt_dout",  {8'h0, dout}, 16'h00A5);
    check("rt_vol",   {12'h0, initial_volume}, 16'hA);
    check("rt_inc",   {15'h0, envelope_increasing}, 16'h0);
    check("rt_sweep", {13'h0, num_envelope_sweeps}, 16'h5);

    // Read masks
    bus_write(16'hFF20, 8'h3F);
    bus_write(16'hFF23, 8'h40);
    bus_read(16'hFF20);
    check("rm_ff20", {8'h0, dout}, 16'h00FF);
    check("rm_len",  {10'h0, length}, 16'h3F);
    bus_read(16'hFF23);
    check("rm_ff23", {8'h0, dout}, 16'h00FF);
    check("rm_single", {15'h0, single}, 16'h1);
    bus_read(16'hFF24);
    check("rm_ff24", {8'h0, dout}, 16'h00FF);

    // Trigger then retrigger two cycles later: one unbroken pulse
    bus_write(16'hFF23, 8'h80);
    idle(1);
    bus_write(16'hFF23, 8'h80);
    idle(6);

    // Master disable ignores writes and silences frame clocks
    sound_enable = 1'b0;
    bus_write(16'hFF22, 8'h77);
    check("dis_nr43", {12'h0, shift_clock_freq}, 16'h0);
    check("dis_len_clk", {15'h0, clk_length_ctr}, 16'h0);
    idle(3);
    sound_enable = 1'b1;
    tick();
    check("reen_len_clk", {15'h0, clk_length_ctr}, 16'h1);
    idle(5);

    // Reset mid-pulse clears outputs without waiting for a clock
    bus_write(16'hFF20, 8'h2A);
    bus_write(16'hFF23, 8'hC0);
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_start",  {15'h0, start}, 16'h0);
    check("mid_rst_len",    {10'h0, length}, 16'h0);
    check("mid_rst_single", {15'h0, single}, 16'h0);
    check("mid_rst_lc",     {15'h0, clk_length_ctr}, 16'h0);
    check("mid_rst_ve",     {15'h0, clk_vol_env}, 16'h0);
    model_reset();
    apply_reset();

    // Random bus traffic with occasional master disable
    for (int i = 0; i < 2000; i++) begin
      sound_enable = ($urandom_range(0, 19) != 0);
      wr   = ($urandom_range(0, 2) == 0);
      rd   = ~wr;
      addr = 16'hFF1F + 16'($urandom_range(0, 5));
      din  = 8'($urandom);
      tick();
    end
    wr = 1'b0;
    sound_enable = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
